i2s_pcm_tx: RTL

- Serial transmitter on the output end of the per-channel delay lines.
- Accepts stereo pairs of 19-bit signed PCM through a valid/ready handshake and buffers them in a small FIFO.
- Generates BCLK/LRCLK and shifts each sample out MSB-first in standard I2S framing to the DAC/codec or downstream link.
- FIFO underflow inserts a silent frame and is flagged.

---
 rtl/i2s_pcm_tx.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/i2s_pcm_tx.sv
// I2S transmitter: buffers stereo PCM pairs in a small FIFO and shifts them out
// MSB-first with the standard one-bit delay. An empty FIFO at frame start sends silence.
module i2s_pcm_tx #(
  parameter int DATA_W     = 19,
  parameter int SLOT_W     = 32,
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] pcm_left,
  input  logic [DATA_W-1:0] pcm_right,
  input  logic              pcm_valid,
  output logic              pcm_ready,
  output logic              bclk,
  output logic              lrclk,
  output logic              sdata,
  output logic              underrun,
  output logic              busy
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(2 * SLOT_W);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_W - 1);
  localparam logic [BIT_W-1:0] SLOT_LEN = BIT_W'(SLOT_W);
  localparam logic [BIT_W-1:0] L_LAST   = BIT_W'(DATA_W);
  localparam logic [BIT_W-1:0] R_LAST   = BIT_W'(SLOT_W + DATA_W);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state_q, state_d;

  logic [2*DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    count, count_next;
  logic                wr_en, pop_en, empty;

  logic [DIV_W-1:0]    div_cnt;
  logic [BIT_W-1:0]    bit_cnt, bit_next;
  logic                started;
  logic [2*DATA_W-1:0] shreg;
  logic                fall, boundary, frame_go, is_data;

  // FIFO bookkeeping
  assign empty  = (count == '0);
  assign wr_en  = pcm_valid & pcm_ready;
  assign pop_en = frame_go & ~empty;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    count_next = count;
    case ({wr_en, pop_en})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state is updated with non-blocking assignments so all registers sample together.
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pcm_ready <= 1'b1;
    end else begin
      if (wr_en)  wr_ptr <= wr_ptr + 1'b1;
      if (pop_en) rd_ptr <= rd_ptr + 1'b1;
      count     <= count_next;
      pcm_ready <= (count_next != FULL_CNT);
    end
  end

  // NOTE: storage array has no reset; emptiness is tracked by count, so contents are don't-care.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {pcm_left, pcm_right};
  end

  // Frame sequencing: the first fall after leaving IDLE is treated as a frame boundary.
  assign fall     = (state_q == RUN) && bclk && (div_cnt == DIV_LAST);
  assign boundary = fall && (!started || (bit_cnt == BIT_LAST));
  assign frame_go = boundary && en;
  assign bit_next = bit_cnt + 1'b1;
  assign is_data  = (bit_next <= L_LAST) || ((bit_next > SLOT_LEN) && (bit_next <= R_LAST));
  assign busy     = (state_q == RUN);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en) state_d = RUN;
      RUN:     if (boundary && !en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt  <= '0;
      bclk     <= 1'b0;
      bit_cnt  <= '0;
      started  <= 1'b0;
      lrclk    <= 1'b0;
      sdata    <= 1'b0;
      underrun <= 1'b0;
      shreg    <= '0;
    end else begin
      underrun <= frame_go && empty;
      if ((state_q != RUN) || (state_d != RUN)) begin
        div_cnt <= '0;
        bclk    <= 1'b0;
        bit_cnt <= '0;
        started <= 1'b0;
        lrclk   <= 1'b0;
        sdata   <= 1'b0;
      end else begin
        if (div_cnt == DIV_LAST) begin
          div_cnt <= '0;
          bclk    <= ~bclk;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
        if (boundary) begin
          bit_cnt <= '0;
          started <= 1'b1;
          lrclk   <= 1'b0;
          sdata   <= 1'b0;
          shreg   <= pop_en ? mem[rd_ptr] : '0;
        end else if (fall) begin
          bit_cnt <= bit_next;
          lrclk   <= (bit_next >= SLOT_LEN);
          // Left then right sample sit back to back in shreg, so one shift serves both slots.
          if (is_data) {sdata, shreg} <= {shreg, 1'b0};
          else         sdata <= 1'b0;
        end
      end
    end
  end

endmodule
